// File: rtl/demux32_8_pkg.sv
// Shared definitions for the 32-to-8 word serializer (demux32_8).
// Holds the FSM state encoding, byte-counter width and the bytes-per-word constant.
package demux32_8_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // IDLE: counter at zero, nothing pending on the output.
  // SEND: a word is being emitted (cnt 1..3, or cnt 0 with the last byte on the output).
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : demux32_8_pkg

// File: rtl/demux32_8.sv
// demux32_8: serializes a 4*DATA_W-bit word into DATA_W-bit bytes, MSB byte first,
// one byte per clk_4f edge, with no bubble between back-to-back words.
// Optional feature: define DEMUX32_8_PARITY_EN to register an even-parity bit
// alongside data_out; without it parity_out is tied low and no parity logic exists.
//
// state | meaning
// IDLE  | cnt == 0, valid_out low, data_out holding the last emitted byte
// SEND  | word in flight (cnt 1..3) or last byte of a word on data_out (cnt 0)
module demux32_8
  import demux32_8_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk_4f,
  input  logic                  reset_L,
  input  logic [4*DATA_W-1:0]   data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  output logic                  parity_out
);

  localparam int WORD_W = BYTES_PER_WORD * DATA_W;

  state_e              state_q, state_d;
  cnt_t                cnt_q,   cnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
  logic                accept;

  // A new word may only be taken once the previous word's last byte is issued.
  assign ready_out = (cnt_q == '0);
  assign accept    = valid_in & ready_out;

  // Next-state: load on acceptance, otherwise shift out the remaining bytes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (accept) begin
      state_d = SEND;
      cnt_d   = cnt_t'(1);
      data_d  = data_in[WORD_W-1 -: DATA_W];
      // Byte 0 goes straight out; keep the rest top-aligned for shifting.
      shreg_d = {data_in[WORD_W-DATA_W-1:0], {DATA_W{1'b0}}};
      valid_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q + cnt_t'(1);
      data_d  = shreg_q[WORD_W-1 -: DATA_W];
      shreg_d = {shreg_q[WORD_W-DATA_W-1:0], {DATA_W{1'b0}}};
      valid_d = 1'b1;
    end else begin
      state_d = IDLE;
    end
  end

  // State, counter, shift register and registered outputs.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

`ifdef DEMUX32_8_PARITY_EN
  logic parity_q;

  // Parity follows data_d, so it holds whenever data_out holds.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity_out = parity_q;
`else
  assign parity_out = 1'b0;
`endif

endmodule : demux32_8

// File: tb/tb_demux32_8.sv
// Self-checking bench for demux32_8: a byte-queue reference model predicts each
// edge's outputs, which are queued at drive time and compared after the edge.
module tb_demux32_8;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        parity_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] pend[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic [9:0] exp_q[$];

  demux32_8 #(.DATA_W(8)) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .parity_out(parity_out)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_par(input logic [7:0] b);
`ifdef DEMUX32_8_PARITY_EN
    return ^b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    pend.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic step(input logic vin, input logic [31:0] din, input string tag);
    logic       m_ready;
    logic [9:0] e;
    valid_in = vin;
    data_in  = din;
    m_ready  = (pend.size() == 0);
    chk({tag, ".ready"}, {31'd0, ready_out}, {31'd0, m_ready});
    if (vin && m_ready) begin
      m_data  = din[31:24];
      pend.push_back(din[23:16]);
      pend.push_back(din[15:8]);
      pend.push_back(din[7:0]);
      m_valid = 1'b1;
    end else if (pend.size() > 0) begin
      m_data  = pend.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    exp_q.push_back({m_valid, exp_par(m_data), m_data});
    @(posedge clk_4f);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".data"},   {24'd0, data_out},   {24'd0, e[7:0]});
    chk({tag, ".valid"},  {31'd0, valid_out},  {31'd0, e[9]});
    chk({tag, ".parity"}, {31'd0, parity_out}, {31'd0, e[8]});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".data"},   {24'd0, data_out},   32'd0);
    chk({tag, ".valid"},  {31'd0, valid_out},  32'd0);
    chk({tag, ".parity"}, {31'd0, parity_out}, 32'd0);
    chk({tag, ".ready"},  {31'd0, ready_out},  32'd1);
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    model_reset();
    @(posedge clk_4f);
    #1;
    chk_reset_state("rst");
    @(posedge clk_4f);
    #1;
    reset_L = 1'b1;

    // Single word, then idle: data_out must hold last byte.
    step(1'b1, 32'h2A59880F, "w1");
    chk("w1.b0", {24'd0, data_out}, 32'h2A);
    step(1'b0, 32'hFFFFFFFF, "w1");
    chk("w1.b1", {24'd0, data_out}, 32'h59);
    step(1'b0, 32'h0, "w1");
    step(1'b0, 32'h0, "w1");
    chk("w1.b3", {24'd0, data_out}, 32'h0F);
    step(1'b0, 32'h0, "w1idle");
    chk("w1.hold", {24'd0, data_out}, 32'h0F);
    step(1'b0, 32'h0, "w1idle");

    // Back-to-back words, no gap.
    step(1'b1, 32'h11223344, "b2b");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, "b2b");
    step(1'b1, 32'hAABBCCDD, "b2b");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, "b2b");
    step(1'b0, 32'h0, "b2bidle");

    // valid_in held high, data changing every cycle.
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, "hold");
    for (int i = 0; i < 5; i++)  step(1'b0, 32'h0, "hold");

    // Ignored requests while busy must not be queued.
    step(1'b1, 32'hCAFEF00D, "busy");
    step(1'b1, 32'h12345678, "busy");
    step(1'b0, 32'h0, "busy");
    step(1'b0, 32'h0, "busy");
    step(1'b0, 32'h0, "busy");

    // Reset mid-word.
    step(1'b1, 32'h11223344, "mid");
    step(1'b0, 32'h0, "mid");
    chk("mid.b1", {24'd0, data_out}, 32'h22);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    chk_reset_state("midrst");
    valid_in = 1'b1;
    data_in  = 32'h55555555;
    @(posedge clk_4f);
    #1;
    chk_reset_state("rstedge");
    reset_L = 1'b1;
    step(1'b1, 32'hDEADBEEF, "post");
    chk("post.b0", {24'd0, data_out}, 32'hDE);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, "post");
    chk("post.b3", {24'd0, data_out}, 32'hEF);
    step(1'b0, 32'h0, "postidle");

    // Parity pattern word.
    step(1'b1, 32'h01030700, "par");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, "par");
    step(1'b0, 32'h0, "paridle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_demux32_8
